// File: rtl/counter_multimode.sv
// N-bit up/down/ping-pong/hold counter with modulo limit, wrap/saturate, load and prescaler.
// Outputs are registered and update on the tick edge itself; there is no backpressure path.
module counter_multimode #(
  parameter int N        = 8,
  parameter int MAX      = 2**N-1,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic         saturate,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] counter,
  output logic         direction,
  output logic         tc
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [N-1:0]  MAX_V      = MAX[N-1:0];
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [N-1:0]  counter_q, counter_d;
  logic          direction_q, direction_d;
  logic          tc_q, tc_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [N-1:0]  cnt_inc, cnt_dec;

  assign cnt_inc = counter_q + 1'b1;
  assign cnt_dec = counter_q - 1'b1;

  always_comb begin
    counter_d   = counter_q;
    direction_d = direction_q;
    tc_d        = 1'b0;
    presc_d     = presc_q;
    tick        = 1'b0;

    if (load) begin
      counter_d = (load_value > MAX_V) ? MAX_V : load_value;
      presc_d   = '0;
    end else if (enable && (mode != MODE_HOLD)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (tick) begin
      case (mode)
        MODE_UP: begin
          if (counter_q < MAX_V) begin
            counter_d = cnt_inc;
            tc_d      = saturate && (cnt_inc == MAX_V);
          end else if (!saturate) begin
            counter_d = '0;
            tc_d      = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (counter_q != '0) begin
            counter_d = cnt_dec;
            tc_d      = saturate && (cnt_dec == '0);
          end else if (!saturate) begin
            counter_d = MAX_V;
            tc_d      = 1'b1;
          end
        end
        MODE_PP: begin
          // Already parked on the bound we are heading for: turn around without a pulse.
          if (direction_q) begin
            if (counter_q >= MAX_V) begin
              counter_d   = cnt_dec;
              direction_d = 1'b0;
            end else begin
              counter_d = cnt_inc;
              if (cnt_inc == MAX_V) begin
                direction_d = 1'b0;
                tc_d        = 1'b1;
              end
            end
          end else begin
            if (counter_q == '0) begin
              counter_d   = cnt_inc;
              direction_d = 1'b1;
            end else begin
              counter_d = cnt_dec;
              if (cnt_dec == '0) begin
                direction_d = 1'b1;
                tc_d        = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      counter_q   <= '0;
      direction_q <= 1'b1;
      tc_q        <= 1'b0;
      presc_q     <= '0;
    end else begin
      counter_q   <= counter_d;
      direction_q <= direction_d;
      tc_q        <= tc_d;
      presc_q     <= presc_d;
    end
  end

  assign counter   = counter_q;
  assign direction = direction_q;
  assign tc        = tc_q;

endmodule

// File: tb/tb_counter_multimode.sv
// Drives a PRESCALE=1 and a PRESCALE=4 counter (both MAX=9) from shared stimulus
// and compares every edge against an integer reference model.
module tb_counter_multimode;

  localparam int N   = 8;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   md;
  logic         sat;
  logic         ld;
  logic [N-1:0] lv;

  logic [N-1:0] cnt0, cnt1;
  logic         dir0, dir1, tc0, tc1;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt[2];
  int m_dir[2];
  int m_tc[2];
  int m_pre[2];
  int ps[2] = '{1, 4};

  always #5 clk = ~clk;

  counter_multimode #(.N(N), .MAX(MAX), .PRESCALE(1)) dut (
    .clock(clk), .reset(rst_n), .enable(en), .mode(md), .saturate(sat),
    .load(ld), .load_value(lv), .counter(cnt0), .direction(dir0), .tc(tc0)
  );

  counter_multimode #(.N(N), .MAX(MAX), .PRESCALE(4)) dut_p4 (
    .clock(clk), .reset(rst_n), .enable(en), .mode(md), .saturate(sat),
    .load(ld), .load_value(lv), .counter(cnt1), .direction(dir1), .tc(tc1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one edge, worked out from the counting rules as integers.
  task automatic model_edge(input int k);
    m_tc[k] = 0;
    if (!rst_n) begin
      m_cnt[k] = 0; m_dir[k] = 1; m_pre[k] = 0;
    end else if (ld) begin
      m_cnt[k] = (int'(lv) > MAX) ? MAX : int'(lv);
      m_pre[k] = 0;
    end else if (en && md != 2'd3) begin
      m_pre[k] = (m_pre[k] + 1) % ps[k];
      if (m_pre[k] == 0) begin
        case (md)
          2'd0: begin
            if (m_cnt[k] == MAX) begin
              if (!sat) begin m_cnt[k] = 0; m_tc[k] = 1; end
            end else begin
              m_cnt[k] = m_cnt[k] + 1;
              m_tc[k]  = (sat && m_cnt[k] == MAX) ? 1 : 0;
            end
          end
          2'd1: begin
            if (m_cnt[k] == 0) begin
              if (!sat) begin m_cnt[k] = MAX; m_tc[k] = 1; end
            end else begin
              m_cnt[k] = m_cnt[k] - 1;
              m_tc[k]  = (sat && m_cnt[k] == 0) ? 1 : 0;
            end
          end
          default: begin
            if (m_dir[k] == 1) begin
              if (m_cnt[k] == MAX) begin m_cnt[k] = MAX - 1; m_dir[k] = 0; end
              else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == MAX) begin m_dir[k] = 0; m_tc[k] = 1; end
              end
            end else begin
              if (m_cnt[k] == 0) begin m_cnt[k] = 1; m_dir[k] = 1; end
              else begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin m_dir[k] = 1; m_tc[k] = 1; end
              end
            end
          end
        endcase
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check({tag, "_cnt_p1"}, int'(cnt0), m_cnt[0]);
    check({tag, "_dir_p1"}, int'(dir0), m_dir[0]);
    check({tag, "_tc_p1"},  int'(tc0),  m_tc[0]);
    check({tag, "_cnt_p4"}, int'(cnt1), m_cnt[1]);
    check({tag, "_dir_p4"}, int'(dir1), m_dir[1]);
    check({tag, "_tc_p4"},  int'(tc1),  m_tc[1]);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input int v);
    ld = 1'b1; lv = N'(v);
    step("load");
    ld = 1'b0;
  endtask

  initial begin
    int tc_seen;
    rst_n = 1'b0; en = 1'b0; md = 2'd0; sat = 1'b0; ld = 1'b0; lv = '0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_dir[k] = 1; m_tc[k] = 0; m_pre[k] = 0;
    end

    steps("reset", 2);
    check("reset_counter", int'(cnt0), 0);
    check("reset_direction", int'(dir0), 1);
    check("reset_tc", int'(tc0), 0);

    // Up, wrap: 1..9 then 0 with the only pulse on the wrap edge.
    rst_n = 1'b1; en = 1'b1; md = 2'd0; sat = 1'b0;
    tc_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step("up_wrap");
      check("up_wrap_seq", int'(cnt0), i % 10);
      tc_seen += int'(tc0);
    end
    check("up_wrap_tc_on_zero", int'(tc0), 1);
    check("up_wrap_tc_count", tc_seen, 1);
    steps("up_more", 4);
    rst_n = 1'b0;
    step("mid_reset");
    check("mid_reset_counter", int'(cnt0), 0);
    rst_n = 1'b1;

    // Up, saturate: reach 9 with tc, then stick.
    sat = 1'b1;
    steps("up_sat", 9);
    check("up_sat_at_max", int'(cnt0), MAX);
    check("up_sat_tc", int'(tc0), 1);
    steps("up_sat_hold", 3);
    check("up_sat_held", int'(cnt0), MAX);
    check("up_sat_no_tc", int'(tc0), 0);

    // Down, wrap from 2: 1, 0, 9 with tc on 9.
    md = 2'd1; sat = 1'b0;
    do_load(2);
    steps("down_wrap", 3);
    check("down_wrap_value", int'(cnt0), MAX);
    check("down_wrap_tc", int'(tc0), 1);

    // Ping-pong from 0 for two full periods.
    md = 2'd2;
    do_load(0);
    steps("pingpong", 40);

    // Load clamps and suppresses tc; reset beats load.
    md = 2'd0; en = 1'b1;
    do_load(200);
    check("load_clamp", int'(cnt0), MAX);
    check("load_no_tc", int'(tc0), 0);
    rst_n = 1'b0; ld = 1'b1; lv = 8'd5;
    step("load_under_reset");
    check("reset_over_load", int'(cnt0), 0);
    ld = 1'b0; rst_n = 1'b1;

    // Prescaled up-count: 12 enabled edges give 3 ticks.
    md = 2'd0; sat = 1'b0; en = 1'b1;
    steps("presc_run", 12);
    check("presc_12_cycles", int'(cnt1), 3);
    for (int i = 0; i < 16; i++) begin
      en = i[0];
      step("presc_toggle");
    end
    en = 1'b1; md = 2'd3;
    steps("hold", 5);
    md = 2'd0;
    steps("after_hold", 3);

    // Randomised traffic with occasional loads, resets and mode changes.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ld    = ($urandom_range(0, 24) == 0);
      lv    = N'($urandom_range(0, 255));
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) sat = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
